// File: rtl/spi_master_ctrl_if.sv
// Command/response bus between the command decoder and spi_master_ctrl.
// Handshake: a transfer on either channel happens on the rising clk edge where
// valid and ready are both high; the source holds its payload stable while
// valid is high and ready is low, and the sink may drop ready at any time.
interface spi_master_ctrl_if #(
    parameter int SLOT_W = 2
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [SLOT_W-1:0] cmd_slot;
    logic              cmd_rw;
    logic [6:0]        cmd_addr;
    logic [7:0]        cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_data;

    // Requester side (command decoder)
    modport master (
        output cmd_valid, cmd_slot, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    // Controller side (spi_master_ctrl)
    modport slave (
        input  cmd_valid, cmd_slot, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator issuing one 16-bit register write/read per command.
// Frame, MSB first: {rw, addr[6:0], data[7:0]}; data is 8'h00 for reads.
// Optional feature macro SPI_MASTER_LOOPBACK_EN adds a loopback input that
// samples the outgoing mosi instead of miso and keeps every ss_n high.
module spi_master_ctrl #(
    parameter int N_slots    = 4,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    spi_master_ctrl_if.slave   bus,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic               loopback,
`endif
    output logic               busy,
    output logic               sck,
    output logic [N_slots-1:0] ss_n,
    output logic               mosi,
    input  logic               miso,
    output logic [2:0]         dbg_state
);
    localparam int SLOT_W = (N_slots > 1) ? $clog2(N_slots) : 1;
    localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;        // cycles left in current phase/half-period
    logic [4:0]        hp_q, hp_d;          // half-period index within SHIFT
    logic [15:0]       tx_q, tx_d;          // outgoing frame, bit 15 drives mosi
    logic [7:0]        rx_q, rx_d;          // last sampled bits
    logic              rw_q, rw_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic              ready_q, ready_d;
    logic              slot_ok;
    logic              sample_bit;
    logic              bus_on;

    assign slot_ok = (int'(slot_q) < N_slots);

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample_bit = loopback ? tx_q[15] : miso;
    assign bus_on     = slot_ok && !loopback;
`else
    assign sample_bit = miso;
    assign bus_on     = slot_ok;
`endif

    // Next-state, counters and shift registers
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hp_d       = hp_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rw_d       = rw_q;
        slot_d     = slot_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    state_d = S_SETUP;
                    cnt_d   = DIV_LOAD;
                    rw_d    = bus.cmd_rw;
                    slot_d  = bus.cmd_slot;
                    tx_d    = {bus.cmd_rw, bus.cmd_addr,
                               bus.cmd_rw ? 8'h00 : bus.cmd_wdata};
                    rx_d    = 8'h00;
                end
            end
            S_SETUP: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_SHIFT;
                    cnt_d   = DIV_LOAD;
                    hp_d    = 5'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = DIV_LOAD;
                    hp_d  = hp_q + 5'd1;
                    // even half-period ends on a rising sck edge, odd on a falling one
                    if (!hp_q[0]) begin
                        rx_d = {rx_q[6:0], sample_bit};
                    end else begin
                        tx_d = {tx_q[14:0], 1'b0};
                    end
                    if (hp_q == 5'd31) begin
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 16'd0) begin
                    if (rw_q) begin
                        state_d    = S_RESP;
                        rsp_data_d = slot_ok ? rx_q : 8'hFF;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers; reset aborts any transfer in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            hp_q       <= 5'd0;
            tx_q       <= 16'd0;
            rx_q       <= 8'h00;
            rw_q       <= 1'b0;
            slot_q     <= '0;
            rsp_data_q <= 8'h00;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hp_q       <= hp_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rw_q       <= rw_d;
            slot_q     <= slot_d;
            rsp_data_q <= rsp_data_d;
            ready_q    <= ready_d;
        end
    end

    // Chip-select decode: one line low from SETUP through HOLD
    always_comb begin
        ss_n = '1;
        if ((state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD) && bus_on) begin
            for (int i = 0; i < N_slots; i++) begin
                if (int'(slot_q) == i) begin
                    ss_n[i] = 1'b0;
                end
            end
        end
    end

    assign sck           = (state_q == S_SHIFT) && hp_q[0];
    assign mosi          = tx_q[15];
    assign busy          = (state_q != S_IDLE);
    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign dbg_state     = state_q;
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
SPI initiator that issues single-register write/read transactions to the converter-card SPI slaves (ADC/DAC control ports) on behalf of the command decoder.
- Accepts one command per valid/ready handshake.
- Frames a 16-bit mode-0 transfer on a shared sck/mosi/miso bus with a per-slot chip select.
- Returns read data through a valid/ready response port.
- Sits between the CMD FIFO decoder and the hardware-side SPI pins (amcs/dmcs via the serializer path).

Parameters:
N_slots, 4, number of chip-select outputs; cmd_slot width is clog2(N_slots), minimum 1.
CLK_DIV, 4, clk cycles per sck half-period; legal range 2..255.
GAP_CYCLES, 8, minimum clk cycles with all ss_n high between transactions.

Ports:
clk  input  1  core clock; all logic on rising edge
reset  input  1  synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_slot  input  clog2(N_slots)  target chip select
cmd_rw  input  1  1 = read, 0 = write
cmd_addr  input  7  register address
cmd_wdata  input  8  write data; ignored for reads
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer accepts read data
rsp_data  output  8  read data
busy  output  1  high from accept until return to IDLE
sck  output  1  SPI clock, idle low (CPOL=0, CPHA=0)
ss_n  output  N_slots  active-low chip selects, one-hot-low when active
mosi  output  1  master out
miso  input  1  master in; pre-synchronised by caller

Behaviour:
- Reset values:
  - sck=0, ss_n all 1, mosi=0.
  - cmd_ready=0 during reset, 1 the cycle after reset deasserts.
  - rsp_valid=0, rsp_data=0, busy=0. FSM=IDLE.
  - A reset mid-transfer aborts immediately. No partial response is produced.
- Frame: 16 bits, MSB first: {cmd_rw, cmd_addr[6:0], data[7:0]}. data = cmd_wdata for writes and 8'h00 for reads.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> (RESP if read) -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch all cmd fields and go to SETUP.
  - cmd_ready drops the following cycle.
- SETUP:
  - ss_n[cmd_slot]=0 from the first SETUP cycle.
  - mosi = frame bit 15.
  - Lasts CLK_DIV cycles.
  - cmd_slot >= N_slots: no ss_n asserted, but the transfer still runs and returns 8'hFF on a read.
- SHIFT:
  - 32 half-periods of CLK_DIV cycles each; a divider counter reloads at each half-period.
  - Rising sck edge: sample miso into the shift register.
  - Falling sck edge: shift mosi to the next bit.
  - sck ends low after the 16th falling edge.
- HOLD: ss_n stays low for CLK_DIV cycles, then all ss_n return high.
- GAP: all ss_n high for GAP_CYCLES cycles.
- RESP (reads only):
  - rsp_data = last 8 sampled bits. rsp_valid=1 and is held with rsp_data stable until rsp_ready.
  - Return to IDLE the cycle after the handshake.
  - If rsp_ready is already high on entry, the handshake completes in one cycle.
- Writes skip RESP. rsp_valid never asserts for writes.
- Timing:
  - ss_n low duration = 34*CLK_DIV cycles.
  - Accept to rsp_valid = 1 + 34*CLK_DIV + GAP_CYCLES cycles.
- No command is accepted while busy. Back-to-back commands are therefore separated by at least GAP_CYCLES of deselected bus.
- cmd_valid deasserting while cmd_ready=0 is legal and has no effect.

Optional Feature:
SPI_MASTER_LOOPBACK_EN
- Defined: adds input port loopback (1 bit). When loopback=1, the shift register samples internal mosi instead of miso, and ss_n stay all high (bus untouched) while the sck/mosi timing is unchanged. A read of address A therefore returns 8'h00 (the frame's data byte). Used for self-test.
- Undefined: no loopback port, and miso is always sampled.

Test Plan:
- Reset then idle: hold reset 5 cycles -> all outputs at reset values; cmd_ready=1 one cycle after release; sck/mosi static for 100 cycles.
- Write slot 0, addr 7'h10, wdata 8'h58, CLK_DIV=4 -> ss_n=4'b1110 for 136 cycles; mosi bits sampled on sck rise = 16'h1058; 16 sck pulses; no rsp_valid; busy low 1+136+8 cycles after accept.
- Read slot 1, addr 7'h10, slave model returns 8'hC8 -> mosi frame 16'h9000; rsp_valid at accept+145 with rsp_data=8'hC8.
- Read with rsp_ready held low 50 cycles -> rsp_valid/rsp_data stable throughout; cmd_valid asserted meanwhile is not accepted; accepted only after response handshake.
- Reset asserted at 10th sck rising edge of a read -> next cycle ss_n=all 1, sck=0, no rsp_valid; next command completes normally.
- Read with cmd_slot=3 and N_slots=3 -> no ss_n falls, rsp_data=8'hFF; with SPI_MASTER_LOOPBACK_EN and loopback=1, read addr 7'h2A -> ss_n all high, rsp_data=8'h00.
